// File: rtl/operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : operand_loader
// Description : Assembles a byte-serial stream into a pair of 32-bit operands.
//               Bytes 0-3 form operand A and bytes 4-7 form operand B. The
//               byte order within an operand is selected by BIG_ENDIAN. A
//               completed pair is held until the consumer takes it.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_loader #(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  byte_cnt
);

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       byte_xfer;
  logic       pair_xfer;
  logic [1:0] lane;

  // Handshake flags come straight from the state register, so neither ready
  // nor valid has a combinational path from the opposite side's handshake.
  assign in_ready  = (state == LOAD);
  assign out_valid = (state == FULL);
  assign byte_xfer = in_valid && in_ready;
  assign pair_xfer = out_valid && out_ready;

  // Byte lane inside the current operand; big-endian mirrors the lane order
  // (3-k is the bitwise inverse of a 2-bit k).
  assign lane = BIG_ENDIAN ? ~byte_cnt[1:0] : byte_cnt[1:0];

  // Next-state: the eighth accepted byte fills the pair, a pair transfer
  // releases it. The transfer cycle itself never accepts a byte.
  always_comb begin
    state_next = state;
    case (state)
      LOAD: if (byte_xfer && (byte_cnt == 3'd7)) state_next = FULL;
      FULL: if (pair_xfer) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  // State and byte counter; flush discards any transfer in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LOAD;
      byte_cnt <= 3'd0;
    end else if (flush) begin
      state    <= LOAD;
      byte_cnt <= 3'd0;
    end else begin
      state <= state_next;
      if (byte_xfer) byte_cnt <= byte_cnt + 3'd1;
    end
  end

  // Operand registers: written one lane per accepted byte, otherwise they
  // keep their last contents (flush deliberately leaves them untouched).
  always_ff @(posedge clk) begin
    if (rst) begin
      out_a <= 32'h0;
      out_b <= 32'h0;
    end else if (!flush && byte_xfer) begin
      if (byte_cnt[2]) out_b[{lane, 3'b000} +: 8] <= in_data;
      else             out_a[{lane, 3'b000} +: 8] <= in_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_loader
// Description : Self-checking bench for operand_loader. One little-endian and
//               one big-endian instance share the stimulus; a byte-level
//               reference model predicts outputs and pushes completed pairs
//               into per-instance scoreboards drained by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic        in_ready_le, out_valid_le, in_ready_be, out_valid_be;
  logic [31:0] out_a_le, out_b_le, out_a_be, out_b_be;
  logic [2:0]  byte_cnt_le, byte_cnt_be;

  operand_loader #(.BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_le), .out_a(out_a_le), .out_b(out_b_le),
    .out_valid(out_valid_le), .out_ready(out_ready), .byte_cnt(byte_cnt_le));

  operand_loader #(.BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_be), .out_a(out_a_be), .out_b(out_b_be),
    .out_valid(out_valid_be), .out_ready(out_ready), .byte_cnt(byte_cnt_be));

  int checks = 0;
  int failures = 0;
  bit armed = 1'b0;

  // Reference model: index 0 = little-endian instance, 1 = big-endian.
  int          m_cnt = 0;
  bit          m_held = 1'b0;
  logic [31:0] m_a [2];
  logic [31:0] m_b [2];
  logic [63:0] sb_le [$];
  logic [63:0] sb_be [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one clock edge's worth of the inputs to the model.
  task automatic model_step();
    int op, pos, ln;
    if (rst) begin
      m_cnt = 0; m_held = 1'b0;
      for (int e = 0; e < 2; e++) begin m_a[e] = 32'h0; m_b[e] = 32'h0; end
      sb_le.delete(); sb_be.delete();
    end else if (flush) begin
      if (m_held) begin void'(sb_le.pop_back()); void'(sb_be.pop_back()); end
      m_held = 1'b0; m_cnt = 0;
    end else if (m_held) begin
      if (out_ready) m_held = 1'b0;
    end else if (in_valid) begin
      op  = m_cnt / 4;
      pos = m_cnt % 4;
      for (int e = 0; e < 2; e++) begin
        ln = (e == 1) ? 3 - pos : pos;
        if (op == 0) m_a[e][ln*8 +: 8] = in_data;
        else         m_b[e][ln*8 +: 8] = in_data;
      end
      m_cnt++;
      if (m_cnt == 8) begin
        m_cnt = 0; m_held = 1'b1;
        sb_le.push_back({m_a[0], m_b[0]});
        sb_be.push_back({m_a[1], m_b[1]});
      end
    end
  endtask

  // Monitor: every consumed pair must match the oldest scoreboard entry.
  always @(negedge clk) begin
    logic [63:0] p;
    if (armed && !rst && !flush && out_ready) begin
      if (out_valid_le) begin
        if (sb_le.size() == 0) begin
          checks++; failures++;
          $display("FAIL pair_le_unexpected actual=%h_%h required=none", out_a_le, out_b_le);
        end else begin
          p = sb_le.pop_front();
          chk("pair_le_a", out_a_le, p[63:32]);
          chk("pair_le_b", out_b_le, p[31:0]);
        end
      end
      if (out_valid_be) begin
        if (sb_be.size() == 0) begin
          checks++; failures++;
          $display("FAIL pair_be_unexpected actual=%h_%h required=none", out_a_be, out_b_be);
        end else begin
          p = sb_be.pop_front();
          chk("pair_be_a", out_a_be, p[63:32]);
          chk("pair_be_b", out_b_be, p[31:0]);
        end
      end
    end
  end

  // One cycle: compare visible state against the model, then clock the model.
  task automatic cycle();
    @(negedge clk);
    if (armed) begin
      chk("valid_le", {31'b0, out_valid_le}, {31'b0, m_held});
      chk("ready_le", {31'b0, in_ready_le}, {31'b0, !m_held});
      chk("cnt_le", {29'b0, byte_cnt_le}, m_cnt);
      chk("a_le", out_a_le, m_a[0]);
      chk("b_le", out_b_le, m_b[0]);
      chk("valid_be", {31'b0, out_valid_be}, {31'b0, m_held});
      chk("ready_be", {31'b0, in_ready_be}, {31'b0, !m_held});
      chk("cnt_be", {29'b0, byte_cnt_be}, m_cnt);
      chk("a_be", out_a_be, m_a[1]);
      chk("b_be", out_b_be, m_b[1]);
    end
    @(posedge clk);
    model_step();
    if (rst) armed = 1'b1;
    #1;
  endtask

  task automatic drive(input bit r, input bit f, input bit v, input logic [7:0] d, input bit ordy);
    rst = r; flush = f; in_valid = v; in_data = d; out_ready = ordy;
    cycle();
  endtask

  initial begin
    logic [7:0] b;
    // Reset
    drive(1, 0, 0, 8'h00, 0);
    drive(1, 0, 0, 8'h00, 0);
    chk("rst_a", out_a_le, 32'h0);
    chk("rst_ready", {31'b0, in_ready_le}, 32'd1);

    // Back-to-back stream, consumer stalled
    for (int i = 0; i < 8; i++) begin
      b = 8'h11 * 8'(i + 1);
      drive(0, 0, 1, b, 0);
    end
    chk("stream_le_a", out_a_le, 32'h44332211);
    chk("stream_le_b", out_b_le, 32'h88776655);
    chk("stream_be_a", out_a_be, 32'h11223344);
    chk("stream_be_b", out_b_be, 32'h55667788);
    chk("stream_valid", {31'b0, out_valid_le}, 32'd1);
    chk("stream_cnt", {29'b0, byte_cnt_le}, 32'd0);

    // Held pair ignores input bytes, then gets consumed
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 8'hFF, 0);
    chk("hold_a", out_a_le, 32'h44332211);
    drive(0, 0, 1, 8'hFF, 1);
    chk("after_xfer_valid", {31'b0, out_valid_le}, 32'd0);
    chk("after_xfer_ready", {31'b0, in_ready_be}, 32'd1);

    // Toggled in_valid
    for (int i = 0; i < 16; i++) drive(0, 0, (i % 2) == 0, 8'($urandom), 0);
    chk("toggle_valid", {31'b0, out_valid_be}, 32'd1);
    drive(0, 0, 0, 8'h00, 1);

    // Flush mid-pair, then a fresh pair
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 8'($urandom), 0);
    drive(0, 1, 1, 8'hAA, 0);
    chk("flush_cnt", {29'b0, byte_cnt_le}, 32'd0);
    for (int i = 0; i < 8; i++) drive(0, 0, 1, 8'($urandom), 0);
    drive(0, 0, 0, 8'h00, 1);

    // Reset while full and being consumed
    for (int i = 0; i < 8; i++) drive(0, 0, 1, 8'($urandom), 0);
    drive(1, 0, 0, 8'h00, 1);
    chk("rstfull_a", out_a_be, 32'h0);
    chk("rstfull_b", out_b_le, 32'h0);
    chk("rstfull_valid", {31'b0, out_valid_le}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 59) == 0,
            ($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0);
    end

    // Drain
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 8'h00, 1);
    chk("sb_le_drained", sb_le.size(), 32'd0);
    chk("sb_be_drained", sb_be.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 Parameter: BIG_ENDIAN, default 0, 0 = first byte of each operand lands in bits [7:0], 1 = first byte lands in bits [31:24].
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 Port: flush  input  1  synchronous abort of the operand pair currently being assembled or held.
REQ-005 Port: in_data  input  8  byte-serial operand stream.
REQ-006 Port: in_valid  input  1  in_data carries a byte this cycle.
REQ-007 Port: in_ready  output  1  block accepts a byte this cycle.
REQ-008 Port: out_a  output  32  assembled operand A, feeds the downstream 8-bit-sliced operand select muxes.
REQ-009 Port: out_b  output  32  assembled operand B.
REQ-010 Port: out_valid  output  1  out_a/out_b hold a complete pair.
REQ-011 Port: out_ready  input  1  downstream consumes the pair this cycle.
REQ-012 Port: byte_cnt  output  3  number of bytes accepted for the current pair, 0..7.

Function
REQ-013 Byte transfer SHALL occur only in a cycle where in_valid=1 and in_ready=1; pair transfer SHALL occur only in a cycle where out_valid=1 and out_ready=1.
REQ-014 FSM SHALL have two states: LOAD (in_ready=1, out_valid=0) and FULL (in_ready=0, out_valid=1); no other output combinations are legal.
REQ-015 In LOAD, accepted bytes 0-3 SHALL form out_a and bytes 4-7 SHALL form out_b, byte k of an operand written to bits [8k+7:8k] when BIG_ENDIAN=0 and to bits [31-8k:24-8k] when BIG_ENDIAN=1.
REQ-016 byte_cnt SHALL increment by 1 on each byte transfer and SHALL hold when in_valid=0.
REQ-017 On the byte transfer at byte_cnt=7, byte_cnt SHALL wrap to 0 and the FSM SHALL enter FULL; out_valid SHALL be 1 in the following cycle (latency: one cycle after the 8th accepted byte).
REQ-018 In FULL, out_a, out_b and byte_cnt SHALL hold stable until pair transfer; in_data SHALL be ignored.
REQ-019 On pair transfer the FSM SHALL return to LOAD in the next cycle; in_ready SHALL be 0 during the transfer cycle itself (no same-cycle bypass), giving a minimum period of 9 cycles per pair.
REQ-020 out_a/out_b SHALL retain their last values in LOAD until overwritten byte by byte; only byte_cnt and out_valid indicate completeness.
REQ-021 flush=1 SHALL, on the next edge, set FSM to LOAD, byte_cnt to 0 and out_valid to 0, discarding any byte or pair transfer in the same cycle; out_a/out_b SHALL be unchanged.
REQ-022 Priority SHALL be rst > flush > transfer.
REQ-023 Outputs in_ready and out_valid SHALL be driven directly from the state register (no combinational path from in_valid or out_ready).

Reset
REQ-024 While rst=1 at an edge: FSM=LOAD, byte_cnt=0, out_valid=0, in_ready=1 after the edge, out_a=32'h0, out_b=32'h0.
REQ-025 rst asserted mid-pair or in FULL SHALL discard all partial/held data identically to REQ-024.
REQ-026 Between power-up and the first reset edge, outputs are undefined and the bench SHALL not check them.

Verification
REQ-027 Stream 11,22,33,44,55,66,77,88 (hex) back-to-back, BIG_ENDIAN=0, out_ready=0 -> out_valid=1 one cycle after 8th byte, out_a=44332211, out_b=88776655, in_ready=0, byte_cnt=0.
REQ-028 Same stream with BIG_ENDIAN=1 -> out_a=11223344, out_b=55667788.
REQ-029 Pair held in FULL with out_ready=0 for 5 cycles while in_valid=1, in_data=FF -> outputs unchanged for all 5 cycles; out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
REQ-030 in_valid toggled 1,0,1,0 per cycle across 8 bytes -> byte_cnt advances only on valid cycles; out_valid rises one cycle after 8th accepted byte.
REQ-031 flush=1 after 5 bytes accepted (in_valid=1 same cycle) -> next cycle byte_cnt=0, out_valid=0; following 8 bytes form a fresh pair correctly.
REQ-032 rst=1 in FULL with out_ready=1 same cycle -> next cycle out_valid=0, out_a=0, out_b=0, byte_cnt=0, in_ready=1.
